// File: rtl/dprf_regfile.sv
// -----------------------------------------------------------------------------
// dprf_regfile
//
// Architectural register file with a per-register in-flight scoreboard.
// Serves the register-read stage's two read ports, accepts one writeback per
// cycle, and tracks outstanding writers per register so that the read stage
// can stall on RAW hazards. Squashed instructions give back their reservation
// through the squash port.
//
// Optional feature macro: DPRF_BYPASS_EN
//   defined   : the current writeback is forwarded to the read ports, and the
//               busy flag drops in the same cycle as the final writeback.
//   undefined : reads return stored data only; busy = (count != 0).
//
// Parameters
//   NREGS   number of architectural registers (AW = $clog2(NREGS))
//   DATA_W  register width
//   CNT_W   width of each pending-writer counter (max 2**CNT_W-1)
//
// Ports
//   i_clk          clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   dprf_ra/rb     read addresses
//   dprf_ra/rb_val read data (combinational)
//   dprf_ra/rb_busy register has an outstanding writer (combinational)
//   iss_valid/rd   instruction writing iss_rd leaves the read stage
//   wb_valid/rd/val writeback
//   sq_valid/rd    issued instruction squashed
//   sb_error       sticky scoreboard over/underflow flag
// -----------------------------------------------------------------------------
module dprf_regfile #(
    parameter  int NREGS  = 16,
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,

    input  logic [AW-1:0]     dprf_ra,
    input  logic [AW-1:0]     dprf_rb,
    output logic [DATA_W-1:0] dprf_ra_val,
    output logic [DATA_W-1:0] dprf_rb_val,
    output logic              dprf_ra_busy,
    output logic              dprf_rb_busy,

    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,

    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic [DATA_W-1:0] wb_val,

    input  logic              sq_valid,
    input  logic [AW-1:0]     sq_rd,

    output logic              sb_error
);

    localparam int SW = CNT_W + 2;
    localparam logic [SW-1:0] CNT_MAX = SW'((2 ** CNT_W) - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [CNT_W-1:0]  r_cnt  [NREGS];
    logic              r_sb_error;

    // -------------------------------------------------------------------------
    // Per-register counter next-state
    // -------------------------------------------------------------------------
    logic [SW-1:0]     w_sum  [NREGS];
    logic [SW-1:0]     w_dec  [NREGS];
    logic [SW-1:0]     w_res  [NREGS];
    logic [CNT_W-1:0]  w_cnt_nxt [NREGS];
    logic [NREGS-1:0]  w_ovf;
    logic [NREGS-1:0]  w_udf;

    // The increment is applied before the decrements so that an issue and a
    // writeback in the same cycle on a saturated counter is not flagged.
    always_comb begin
        w_ovf = '0;
        w_udf = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            w_sum[r]     = SW'(r_cnt[r]) + SW'(iss_valid && (iss_rd == AW'(r)));
            w_dec[r]     = SW'(wb_valid && (wb_rd == AW'(r)))
                         + SW'(sq_valid && (sq_rd == AW'(r)));
            w_res[r]     = '0;
            w_cnt_nxt[r] = r_cnt[r];
            if (w_sum[r] < w_dec[r]) begin
                w_udf[r]     = 1'b1;
                w_cnt_nxt[r] = '0;
            end else begin
                w_res[r] = w_sum[r] - w_dec[r];
                if (w_res[r] > CNT_MAX) begin
                    w_ovf[r]     = 1'b1;
                    w_cnt_nxt[r] = '1;
                end else begin
                    w_cnt_nxt[r] = w_res[r][CNT_W-1:0];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequential update
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (wb_valid) begin
            r_regs[wb_rd] <= wb_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sb_error <= 1'b0;
        end else if (|(w_ovf | w_udf)) begin
            r_sb_error <= 1'b1;
        end
    end

    assign sb_error = r_sb_error;

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] w_ra_cnt;
    logic [CNT_W-1:0] w_rb_cnt;

    assign w_ra_cnt = r_cnt[dprf_ra];
    assign w_rb_cnt = r_cnt[dprf_rb];

`ifdef DPRF_BYPASS_EN
    logic w_ra_wb_hit;
    logic w_rb_wb_hit;
    logic w_ra_iss_hit;
    logic w_rb_iss_hit;

    assign w_ra_wb_hit  = wb_valid  && (wb_rd  == dprf_ra);
    assign w_rb_wb_hit  = wb_valid  && (wb_rd  == dprf_rb);
    assign w_ra_iss_hit = iss_valid && (iss_rd == dprf_ra);
    assign w_rb_iss_hit = iss_valid && (iss_rd == dprf_rb);

    assign dprf_ra_val = w_ra_wb_hit ? wb_val : r_regs[dprf_ra];
    assign dprf_rb_val = w_rb_wb_hit ? wb_val : r_regs[dprf_rb];

    // The last outstanding writer completing this cycle is already forwarded,
    // so busy can drop now -- unless a new writer issues in the same cycle.
    assign dprf_ra_busy = (w_ra_cnt != '0)
                       && !((w_ra_cnt == CNT_W'(1)) && w_ra_wb_hit && !w_ra_iss_hit);
    assign dprf_rb_busy = (w_rb_cnt != '0)
                       && !((w_rb_cnt == CNT_W'(1)) && w_rb_wb_hit && !w_rb_iss_hit);
`else
    assign dprf_ra_val  = r_regs[dprf_ra];
    assign dprf_rb_val  = r_regs[dprf_rb];
    assign dprf_ra_busy = (w_ra_cnt != '0);
    assign dprf_rb_busy = (w_rb_cnt != '0);
`endif

endmodule

// File: tb/tb_dprf_regfile.sv
// -----------------------------------------------------------------------------
// tb_dprf_regfile
//
// Self-checking bench for dprf_regfile. A behavioural model of the register
// contents and pending counts produces the expected outputs for each cycle;
// these are queued when the stimulus is applied and popped when the DUT
// outputs are sampled. Honours DPRF_BYPASS_EN for its expectations.
// -----------------------------------------------------------------------------
module tb_dprf_regfile;

    localparam int NREGS  = 16;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;
    localparam int AW     = 4;
`ifdef DPRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b0;
    logic [AW-1:0]     dprf_ra = '0;
    logic [AW-1:0]     dprf_rb = '0;
    logic [DATA_W-1:0] dprf_ra_val;
    logic [DATA_W-1:0] dprf_rb_val;
    logic              dprf_ra_busy;
    logic              dprf_rb_busy;
    logic              iss_valid = 1'b0;
    logic [AW-1:0]     iss_rd = '0;
    logic              wb_valid = 1'b0;
    logic [AW-1:0]     wb_rd = '0;
    logic [DATA_W-1:0] wb_val = '0;
    logic              sq_valid = 1'b0;
    logic [AW-1:0]     sq_rd = '0;
    logic              sb_error;

    dprf_regfile #(
        .NREGS (NREGS),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .dprf_ra     (dprf_ra),
        .dprf_rb     (dprf_rb),
        .dprf_ra_val (dprf_ra_val),
        .dprf_rb_val (dprf_rb_val),
        .dprf_ra_busy(dprf_ra_busy),
        .dprf_rb_busy(dprf_rb_busy),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_val      (wb_val),
        .sq_valid    (sq_valid),
        .sq_rd       (sq_rd),
        .sb_error    (sb_error)
    );

    always #5 i_clk = ~i_clk;

    // -------------------------------------------------------------------------
    // Model and scoreboard
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] m_reg [NREGS];
    int                m_cnt [NREGS];
    bit                m_err;
    int unsigned       cyc;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [31:0] exp_val(input logic [AW-1:0] a);
        if (BYP && wb_valid && wb_rd == a) return wb_val;
        return m_reg[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [AW-1:0] a);
        bit wh, ih;
        wh = wb_valid && (wb_rd == a);
        ih = iss_valid && (iss_rd == a);
        if (BYP) return {31'b0, (m_cnt[a] != 0) && !(m_cnt[a] == 1 && wh && !ih)};
        return {31'b0, m_cnt[a] != 0};
    endfunction

    task automatic push_expected();
        exp_q.push_back('{$sformatf("ra_val@%0d", cyc),  exp_val(dprf_ra)});
        exp_q.push_back('{$sformatf("rb_val@%0d", cyc),  exp_val(dprf_rb)});
        exp_q.push_back('{$sformatf("ra_busy@%0d", cyc), exp_busy(dprf_ra)});
        exp_q.push_back('{$sformatf("rb_busy@%0d", cyc), exp_busy(dprf_rb)});
        exp_q.push_back('{$sformatf("sb_error@%0d", cyc), {31'b0, m_err}});
    endtask

    task automatic compare_outputs();
        exp_t e;
        e = exp_q.pop_front(); check_val(e.tag, dprf_ra_val, e.exp);
        e = exp_q.pop_front(); check_val(e.tag, dprf_rb_val, e.exp);
        e = exp_q.pop_front(); check_val(e.tag, {31'b0, dprf_ra_busy}, e.exp);
        e = exp_q.pop_front(); check_val(e.tag, {31'b0, dprf_rb_busy}, e.exp);
        e = exp_q.pop_front(); check_val(e.tag, {31'b0, sb_error}, e.exp);
    endtask

    // State after the coming rising edge, from the currently driven inputs.
    task automatic model_update();
        int n;
        if (!i_reset_n) begin
            model_clear();
            return;
        end
        for (int r = 0; r < NREGS; r++) begin
            n = m_cnt[r]
              + int'(iss_valid && iss_rd == AW'(r))
              - int'(wb_valid  && wb_rd  == AW'(r))
              - int'(sq_valid  && sq_rd  == AW'(r));
            if (n > 3) begin n = 3; m_err = 1'b1; end
            if (n < 0) begin n = 0; m_err = 1'b1; end
            m_cnt[r] = n;
        end
        if (wb_valid) m_reg[wb_rd] = wb_val;
    endtask

    // One cycle: drive at the falling edge, sample 2 time units later.
    task automatic step(input bit iv, input logic [AW-1:0] ir,
                        input bit wv, input logic [AW-1:0] wr, input logic [31:0] wd,
                        input bit sv, input logic [AW-1:0] sr,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        @(negedge i_clk);
        iss_valid = iv; iss_rd = ir;
        wb_valid  = wv; wb_rd  = wr; wb_val = wd;
        sq_valid  = sv; sq_rd  = sr;
        dprf_ra   = ra; dprf_rb = rb;
        push_expected();
        #2;
        compare_outputs();
        model_update();
        cyc++;
    endtask

    task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        step(0, '0, 0, '0, '0, 0, '0, ra, rb);
    endtask

    task automatic issue(input logic [AW-1:0] r, input logic [AW-1:0] ra);
        step(1, r, 0, '0, '0, 0, '0, ra, ra);
    endtask

    task automatic wback(input logic [AW-1:0] r, input logic [31:0] d,
                         input logic [AW-1:0] ra);
        step(0, '0, 1, r, d, 0, '0, ra, ra);
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_reset_n = 1'b0;
        model_clear();
        idle(4'd1, 4'd2);
        idle(4'd0, 4'd15);
        i_reset_n = 1'b1;
        idle(4'd1, 4'd5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        model_clear();
        apply_reset();

        // Basic write/read on r5
        issue(4'd5, 4'd5);
        wback(4'd5, 32'hDEADBEEF, 4'd5);
        idle(4'd5, 4'd0);

        // Scoreboard round trip on r3
        issue(4'd3, 4'd3);
        issue(4'd3, 4'd3);
        wback(4'd3, 32'h3333_0001, 4'd3);
        idle(4'd3, 4'd3);
        wback(4'd3, 32'h3333_0002, 4'd3);
        idle(4'd3, 4'd5);

        // Squash on r7
        issue(4'd7, 4'd7);
        step(0, '0, 0, '0, '0, 1, 4'd7, 4'd7, 4'd7);
        idle(4'd7, 4'd3);

        // Writeback + squash to r9 with count 2
        issue(4'd9, 4'd9);
        issue(4'd9, 4'd9);
        step(0, '0, 1, 4'd9, 32'h9999_9999, 1, 4'd9, 4'd9, 4'd9);
        idle(4'd9, 4'd9);

        // Issue + writeback to r4 in one cycle keeps count at 1
        issue(4'd4, 4'd4);
        step(1, 4'd4, 1, 4'd4, 32'h4444_4444, 0, '0, 4'd4, 4'd9);
        idle(4'd4, 4'd4);
        wback(4'd4, 32'h4444_5555, 4'd4);
        idle(4'd4, 4'd9);

        // Overflow on r1
        for (int i = 0; i < 4; i++) issue(4'd1, 4'd1);
        idle(4'd1, 4'd3);

        // Mid-run reset with non-zero counts
        apply_reset();
        idle(4'd5, 4'd1);

        // Underflow on r2
        wback(4'd2, 32'h2222_2222, 4'd2);
        idle(4'd2, 4'd2);

        // Random traffic from a clean state
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, 15)),
                 AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dprf_regfile.md
# dprf_regfile

Architectural register file with per-register in-flight scoreboard. It serves as the responder for the register-read stage's two read ports (`dprf_ra`/`dprf_rb` → `dprf_ra_val`/`dprf_rb_val`) and takes one writeback per cycle from the end of the pipeline. It tracks outstanding writers per register so the read stage can raise a stall on a RAW hazard. Squashed instructions release their scoreboard reservation through a dedicated squash port.

## Interface

Parameters:
- `NREGS`, 16, number of architectural registers; address width `AW = $clog2(NREGS)`.
- `DATA_W`, 32, register width.
- `CNT_W`, 2, width of each per-register pending-writer counter; maximum count `2**CNT_W-1`.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `dprf_ra`, `dprf_rb`  in  AW  read addresses.
- `dprf_ra_val`, `dprf_rb_val`  out  DATA_W  read data, combinational.
- `dprf_ra_busy`, `dprf_rb_busy`  out  1  register has an outstanding writer; combinational.
- `iss_valid`  in  1  an instruction writing `iss_rd` leaves the read stage this cycle.
- `iss_rd`  in  AW  destination register of the issuing instruction.
- `wb_valid`  in  1  writeback this cycle.
- `wb_rd`  in  AW  writeback destination.
- `wb_val`  in  DATA_W  writeback data.
- `sq_valid`  in  1  an issued instruction is squashed this cycle.
- `sq_rd`  in  AW  destination register of the squashed instruction.
- `sb_error`  out  1  sticky scoreboard over/underflow flag; cleared only by reset.

## Operation

- Storage: `NREGS` x `DATA_W` flops plus `NREGS` x `CNT_W` pending counters `cnt[r]`.
- Write: on `wb_valid`, `reg[wb_rd] <= wb_val` at the clock edge.
- No hardwired zero register; all registers are writable.
- Counter update per register `r`, every cycle:
  - net = `(iss_valid && iss_rd==r) − (wb_valid && wb_rd==r) − (sq_valid && sq_rd==r)`.
  - `cnt[r] <= cnt[r] + net`. A net of −2 is legal when the count is ≥2.
- Overflow: if the increment would exceed `2**CNT_W-1`, the count holds at the maximum and `sb_error` is set.
- Underflow: if the count would go below 0, it holds at 0 and `sb_error` is set.
- Busy: `dprf_ra_busy = (cnt[dprf_ra] != 0)`. With bypass enabled, the busy term is masked as described under Configuration. `dprf_rb_busy` is identical for port B.
- Read data: `reg[addr]`. With bypass enabled, the current writeback is forwarded (see Configuration).
- Both read ports are fully independent. Reading the same address on both ports is legal.
- Reset (async, `i_reset_n` low): all registers = 0, all `cnt` = 0, `sb_error` = 0.
  - Outputs during and after reset: `*_val` = 0 and `*_busy` = 0 for any address until the first write.
  - Reset asserted mid-operation discards all pending counts immediately. No writeback is applied during the reset cycle.

## Timing

- Reads and busy: zero latency, combinational from `dprf_ra`/`dprf_rb`, `cnt` and (when bypassing) the `wb_*` inputs.
- Write visibility:
  - With bypass: same cycle.
  - Without bypass: read data shows the new value starting the cycle after the `wb_valid` edge.
- Scoreboard latency:
  - An issue at edge N makes the register busy from cycle N+1.
  - A writeback in cycle M clears busy (count 1→0) from cycle M+1. With bypass, busy is already clear in cycle M.
- Simultaneous events:
  - Issue and writeback to the same register in one cycle: count unchanged. Read data = `wb_val` with bypass, old value without.
  - Writeback and squash to the same register in one cycle: count decrements by 2.
- No handshake back-pressure: the block always accepts writes. Avoiding overflow by stalling on `*_busy` is the read stage's responsibility.

## Configuration

- `DPRF_BYPASS_EN` defined:
  - When `wb_valid && wb_rd==addr`, read data = `wb_val`.
  - Busy = `cnt[addr] != 0 && !(cnt[addr]==1 && wb_valid && wb_rd==addr && !(iss_valid && iss_rd==addr))`.
- `DPRF_BYPASS_EN` undefined:
  - Read data = stored value only.
  - Busy = `cnt[addr] != 0`.
  - A dependent instruction therefore stalls one cycle longer.

## Test plan

- Reset: hold `i_reset_n` low mid-run with counts non-zero, then release. Required: all reads return 0, all busy = 0, `sb_error` = 0.
- Basic write/read: write `0xDEADBEEF` to r5.
  - Bypass on: `dprf_ra=5` returns `0xDEADBEEF` in the same cycle.
  - Bypass off: returns 0 in that cycle and `0xDEADBEEF` in the next.
- Scoreboard round trip: issue r3 twice (count 2), then write back r3 once (busy stays 1), then write back again. Required: busy 0 from the cycle after the second writeback (bypass off), or during it (bypass on).
- Squash: issue r7, then squash r7. Required: busy 0 the following cycle; register value unchanged; `sb_error` stays 0.
- Simultaneous events: with count=2 on r9, apply writeback and squash to r9 in one cycle. Required: count goes to 0. Issue and writeback to r4 in one cycle: count unchanged.
- Error: issue r1 four times without writeback (count saturates at 3, `sb_error`=1). Separately, after reset, writeback r2 with count 0. Required: `sb_error`=1 and count stays 0.
